// File: rtl/interrupt_controller_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared constants for the interrupt controller and the program-counter block
// it steers.
//   PC_NEXTX_*  : 3-bit next-address select codes driven on PC_NEXTX
//   INTV0/INTV1 : fixed handler entry addresses selected by the *_INTV* codes
// -----------------------------------------------------------------------------
package interrupt_controller_pkg;

    localparam int PC_NEXTX_W = 3;

    // Next-address select codes understood by the program counter.
    localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_NEXT  = 3'd0; // sequential
    localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTV0 = 3'd1; // INT0 vector
    localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTV1 = 3'd2; // INT1 vector
    localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTR0 = 3'd3; // INT0 return address
    localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTR1 = 3'd4; // INT1 return address

    // Handler entry addresses behind the vector select codes.
    localparam logic [15:0] INTV0 = 16'h0004;
    localparam logic [15:0] INTV1 = 16'h0008;

endpackage

// File: rtl/interrupt_controller_request_latch.sv
// -----------------------------------------------------------------------------
// int_request_latch
// Per-line request capture: rising-edge detect, sticky pending bit and the
// line's enable bit.
//   CLK, RESETN : clock, synchronous active-low reset
//   req         : raw request line (synchronous to CLK)
//   en_ld       : load enable bit from en_din
//   en_din      : new enable value
//   clr         : clear pending (request is being taken)
//   pending     : request captured and not yet taken
//   enabled     : line enable
// -----------------------------------------------------------------------------
module int_request_latch (
    input  logic CLK,
    input  logic RESETN,
    input  logic req,
    input  logic en_ld,
    input  logic en_din,
    input  logic clr,
    output logic pending,
    output logic enabled
);

    logic req_prev;
    logic req_rise;

    // Only a 0->1 transition counts, so a line held high is captured once.
    assign req_rise = req & ~req_prev;

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RESETN) begin
            req_prev <= 1'b0;
            pending  <= 1'b0;
            enabled  <= 1'b0;
        end else begin
            req_prev <= req;
            if (en_ld)
                enabled <= en_din;
            // A fresh edge beats a simultaneous clear: the new request must not be lost.
            if (req_rise)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Two-level priority interrupt controller sequenced by instruction phases.
// Decisions are taken at COMMIT; the resulting PC redirect, save strobe and
// acknowledge happen on the following FETCH.
//   CLK, RESETN              : clock, synchronous active-low reset
//   FETCH, DECODE, COMMIT    : instruction-phase strobes (one-hot or idle)
//   INT0_REQ, INT1_REQ       : request lines, INT0 has priority
//   INT_EN_LD, INT_EN_DIN    : enable mask load strobe and value
//   RETI                     : return-from-interrupt, valid with COMMIT
//   PC_LD_INT0X/INT1X        : save sequential return address
//   PC_NEXTX                 : next-address select (PC_NEXTX_* codes)
//   INT0_ACK, INT1_ACK       : one-cycle acknowledges
//   IN_INT0, IN_INT1         : handler-active flags
//   INT_PENDING              : pending bits {INT1, INT0}
// -----------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  FETCH,
    input  logic                  DECODE,
    input  logic                  COMMIT,
    input  logic                  INT0_REQ,
    input  logic                  INT1_REQ,
    input  logic                  INT_EN_LD,
    input  logic [1:0]            INT_EN_DIN,
    input  logic                  RETI,
    output logic                  PC_LD_INT0X,
    output logic                  PC_LD_INT1X,
    output logic [PC_NEXTX_W-1:0] PC_NEXTX,
    output logic                  INT0_ACK,
    output logic                  INT1_ACK,
    output logic                  IN_INT0,
    output logic                  IN_INT1,
    output logic [1:0]            INT_PENDING
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TAKE0 = 2'd1,
        S_TAKE1 = 2'd2,
        S_RET   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] enabled;
    logic       ret_done;

    int_request_latch u_line0 (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .req     (INT0_REQ),
        .en_ld   (INT_EN_LD),
        .en_din  (INT_EN_DIN[0]),
        .clr     (INT0_ACK),
        .pending (INT_PENDING[0]),
        .enabled (enabled[0])
    );

    int_request_latch u_line1 (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .req     (INT1_REQ),
        .en_ld   (INT_EN_LD),
        .en_din  (INT_EN_DIN[1]),
        .clr     (INT1_ACK),
        .pending (INT_PENDING[1]),
        .enabled (enabled[1])
    );

    always_ff @(posedge CLK) begin
        if (!RESETN)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            IN_INT0 <= 1'b0;
            IN_INT1 <= 1'b0;
        end else begin
            if (INT0_ACK)
                IN_INT0 <= 1'b1;
            if (INT1_ACK)
                IN_INT1 <= 1'b1;
            // Handlers nest only as INT1 under INT0, so INT0 always unwinds first.
            if (ret_done) begin
                if (IN_INT0)
                    IN_INT0 <= 1'b0;
                else
                    IN_INT1 <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_nxt   = state;
        PC_NEXTX    = PC_NEXTX_NEXT;
        PC_LD_INT0X = 1'b0;
        PC_LD_INT1X = 1'b0;
        INT0_ACK    = 1'b0;
        INT1_ACK    = 1'b0;
        ret_done    = 1'b0;

        case (state)
            S_IDLE: begin
                if (COMMIT) begin
                    if (RETI && (IN_INT0 || IN_INT1))
                        state_nxt = S_RET;
                    else if (INT_PENDING[0] && enabled[0] && !IN_INT0)
                        state_nxt = S_TAKE0;
                    else if (INT_PENDING[1] && enabled[1] && !IN_INT0 && !IN_INT1)
                        state_nxt = S_TAKE1;
                end
            end
            S_TAKE0: begin
                PC_NEXTX = PC_NEXTX_INTV0;
                if (FETCH) begin
                    PC_LD_INT0X = 1'b1;
                    INT0_ACK    = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_TAKE1: begin
                PC_NEXTX = PC_NEXTX_INTV1;
                if (FETCH) begin
                    PC_LD_INT1X = 1'b1;
                    INT1_ACK    = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_RET: begin
                PC_NEXTX = IN_INT0 ? PC_NEXTX_INTR0 : PC_NEXTX_INTR1;
                if (FETCH) begin
                    ret_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // While reset is asserted the pending operation is abandoned: nothing
        // may reach the program counter even if FETCH arrives in that cycle.
        if (!RESETN) begin
            PC_NEXTX    = PC_NEXTX_NEXT;
            PC_LD_INT0X = 1'b0;
            PC_LD_INT1X = 1'b0;
            INT0_ACK    = 1'b0;
            INT1_ACK    = 1'b0;
            ret_done    = 1'b0;
        end
    end

    // The sequencer relies on phases never overlapping.
    a_one_phase : assert property (@(posedge CLK) disable iff (!RESETN)
        $onehot0({FETCH, DECODE, COMMIT}));

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: RESETN  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: FETCH, DECODE, COMMIT  in  1 each  instruction-phase strobes, at most one high per cycle.
REQ-004 SHALL have ports: INT0_REQ, INT1_REQ  in  1 each  interrupt request lines, synchronous to CLK; INT0 highest priority.
REQ-005 SHALL have ports: INT_EN_LD  in  1  mask load strobe; INT_EN_DIN  in  2  new enable bits, bit0=INT0, bit1=INT1.
REQ-006 SHALL have port: RETI  in  1  decoded return-from-interrupt, valid during COMMIT.
REQ-007 SHALL have ports: PC_LD_INT0X, PC_LD_INT1X  out  1 each  save-return-address strobes to the program counter.
REQ-008 SHALL have port: PC_NEXTX  out  3  next-address select to the program counter, encoded with the shared PC_NEXTX_* constants.
REQ-009 SHALL have ports: INT0_ACK, INT1_ACK  out  1 each  one-cycle acknowledge pulses.
REQ-010 SHALL have ports: IN_INT0, IN_INT1  out  1 each  handler-active flags; INT_PENDING  out  2  pending bits.

Function
REQ-011 Pending bit n SHALL set on a rising edge of INTn_REQ (prev 0, now 1); a level held high SHALL NOT re-set it after clearing.
REQ-012 Pending bits SHALL be set regardless of enable; a masked request SHALL stay pending until enabled and taken.
REQ-013 INT_EN_LD=1 SHALL load enables from INT_EN_DIN on the next edge, independent of phase.
REQ-014 FSM states: IDLE, TAKE0, TAKE1, RET; decisions made only in a COMMIT cycle while in IDLE.
REQ-015 At COMMIT with RETI=1 and IN_INT0 or IN_INT1 set: next state RET; RETI SHALL win over any simultaneous take.
REQ-016 Else at COMMIT: INT0 pending, enabled, IN_INT0=0 -> TAKE0 (preempts an active INT1 handler).
REQ-017 Else at COMMIT: INT1 pending, enabled, IN_INT0=0, IN_INT1=0 -> TAKE1.
REQ-018 RETI with neither IN flag set SHALL be ignored (stay IDLE, PC_NEXTX=PC_NEXTX_NEXT).
REQ-019 PC_NEXTX SHALL decode from state: IDLE->NEXT, TAKE0->INTV0, TAKE1->INTV1, RET->INTR0 if IN_INT0 else INTR1.
REQ-020 PC_LD_INTnX SHALL be high only in the FETCH cycle while in TAKEn, saving the sequential next address.
REQ-021 On the FETCH cycle in TAKEn: clear pending n, set IN_INTn, pulse INTn_ACK for exactly that cycle, return to IDLE.
REQ-022 On the FETCH cycle in RET: clear IN_INT0 if set, else clear IN_INT1; return to IDLE.
REQ-023 A new rising edge of INTn_REQ in the same cycle pending n is cleared SHALL leave pending n set.
REQ-024 TAKE/RET states SHALL hold, outputs stable, through DECODE and idle cycles until the next FETCH.
REQ-025 Latency: request edge to pending = 1 cycle; take occurs at the first qualifying COMMIT thereafter.

Reset
REQ-026 RESETN=0 at a rising edge SHALL force: state IDLE, pending 00, enables 00, IN_INT0/IN_INT1 0, request edge history 0.
REQ-027 During/after reset outputs SHALL be: PC_NEXTX=PC_NEXTX_NEXT, PC_LD_INT0X/1X=0, INT0_ACK/INT1_ACK=0.
REQ-028 Reset mid-TAKE/RET SHALL abandon the operation; no strobe or ack SHALL be emitted for it.

Structure
REQ-029 PC_NEXTX_* codes, INTV0=0x0004, INTV1=0x0008 SHALL come from the shared constants include; FSM state codes SHALL be local.
REQ-030 Edge detection plus pending/enable logic for one line MAY be a sub-module, int_request_latch, instanced twice; no other sub-modules.

Verification
REQ-031 Enable 11; pulse INT1_REQ; COMMIT -> next FETCH: PC_NEXTX=INTV1 (vector 0x0008), PC_LD_INT1X=1, INT1_ACK=1, IN_INT1=1.
REQ-032 In INT1 handler, pulse INT0_REQ; COMMIT -> FETCH selects INTV0 (0x0004), PC_LD_INT0X=1; IN_INT0=1, IN_INT1 stays 1.
REQ-033 Then RETI at COMMIT -> FETCH selects INTR0, IN_INT0=0; second RETI -> INTR1 selected, IN_INT1=0.
REQ-034 Enables 00, pulse INT0_REQ, 3 COMMITs -> no take, INT_PENDING=01; load enables 01 -> next COMMIT/FETCH takes INT0.
REQ-035 RETI and new INT1 pending at the same COMMIT -> RET first; INT1 taken at the following COMMIT.
REQ-036 RESETN=0 during TAKE0 before FETCH -> no PC_LD_INT0X, no INT0_ACK; all outputs at REQ-027 values.
